// File: rtl/fifo_pkg.sv
// Shared helpers and defaults for the show-ahead FIFO: clog2, default sizes,
// occupancy arithmetic and the error-flag record.
package fifo_pkg;

  localparam int DEF_DATA_DEPTH = 512;
  localparam int DEF_W_DATA     = 64;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Next occupancy from current occupancy and the accepted write/read strobes.
  function automatic logic [31:0] next_count(input logic [31:0] cnt, input logic wr_ok,
                                             input logic rd_ok);
    return cnt + 32'(wr_ok) - 32'(rd_ok);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// No read-during-write handling here; the FIFO wrapper owns the bypass.
module sdp_ram #(
  parameter int DEPTH  = 512,
  parameter int W_DATA = 64,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W_DATA-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [W_DATA-1:0] rd_data
);

  logic [W_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock show-ahead FIFO on inferred RAM with programmable thresholds,
// sticky error flags and a high-water mark.
module sync_fifo_v2 import fifo_pkg::*; #(
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int W_DATA     = DEF_W_DATA,
  parameter int W_COUNT    = clog2(DATA_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_DATA-1:0]  wr_data,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [W_COUNT-1:0] af_level,
  input  logic [W_COUNT-1:0] ae_level,
  input  logic               err_clr,
  output logic [W_DATA-1:0]  rd_data,
  output logic [W_COUNT-1:0] words_used,
  output logic               fifo_is_empty,
  output logic               fifo_is_full,
  output logic               fifo_almost_full,
  output logic               fifo_almost_empty,
  output logic               overflow,
  output logic               underflow,
  output logic [W_COUNT-1:0] high_water
);

  localparam int AW = clog2(DATA_DEPTH);
  localparam logic [W_COUNT-1:0] DEPTH_C = W_COUNT'(DATA_DEPTH);

  if (DATA_DEPTH < 4 || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_v2: DATA_DEPTH must be a power of 2 and >= 4");
  end
  if (W_COUNT < clog2(DATA_DEPTH + 1)) begin : g_bad_count
    $error("sync_fifo_v2: W_COUNT too narrow to hold DATA_DEPTH");
  end

  logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [W_COUNT-1:0] cnt_nxt, hw_nxt;
  logic [W_DATA-1:0]  ram_q, byp_data;
  logic               wr_ok, rd_ok, sel_byp;
  err_t               err_q, err_d;

  assign wr_ok      = wr_en & (~fifo_is_full | rd_en);
  assign rd_ok      = rd_en & ~fifo_is_empty;
  assign rd_ptr_nxt = rd_ptr + AW'(rd_ok);
  assign cnt_nxt    = W_COUNT'(next_count(32'(words_used), wr_ok, rd_ok));

  // Sets take priority over err_clr so an error in the clearing cycle is kept.
  always_comb begin
    err_d.overflow  = (wr_en & fifo_is_full & ~rd_en) | (err_q.overflow & ~err_clr);
    err_d.underflow = (rd_en & fifo_is_empty) | (err_q.underflow & ~err_clr);
    hw_nxt = high_water;
    if (err_clr || cnt_nxt > high_water) hw_nxt = cnt_nxt;
  end

  // RAM is addressed with the next read pointer so its registered output
  // already shows the new head one edge after a pop.
  sdp_ram #(.DEPTH(DATA_DEPTH), .W_DATA(W_DATA), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_nxt),
    .rd_data (ram_q)
  );

  assign rd_data = sel_byp ? byp_data : ram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      words_used        <= '0;
      fifo_is_empty     <= 1'b1;
      fifo_is_full      <= 1'b0;
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
      err_q             <= '0;
      high_water        <= '0;
      sel_byp           <= 1'b1;
      byp_data          <= '0;
    end else begin
      wr_ptr            <= wr_ptr + AW'(wr_ok);
      rd_ptr            <= rd_ptr_nxt;
      words_used        <= cnt_nxt;
      fifo_is_empty     <= (cnt_nxt == '0);
      fifo_is_full      <= (cnt_nxt == DEPTH_C);
      fifo_almost_full  <= (cnt_nxt >= af_level);
      fifo_almost_empty <= (cnt_nxt <= ae_level);
      err_q             <= err_d;
      high_water        <= hw_nxt;
      // Same-address write/read: RAM returns stale data, so forward the write.
      // When going empty, freeze the last word instead of exposing stale RAM.
      if (wr_ok && wr_ptr == rd_ptr_nxt) begin
        sel_byp  <= 1'b1;
        byp_data <= wr_data;
      end else if (cnt_nxt == '0) begin
        sel_byp  <= 1'b1;
        byp_data <= rd_data;
      end else begin
        sel_byp  <= 1'b0;
      end
    end
  end

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

endmodule
